// File: rtl/riscv_retire_monitor.sv
// riscv_retire_monitor
//   Retirement bookkeeping at the writeback end of the core. Counts committed
//   instructions, keeps the observation value of the latest commit and raises a
//   sticky HALT once the terminate pair (li ra,12 ; jalr x0,0(ra)) has committed.
//
// Ports
//   CLK          in   1   clock, all state on posedge
//   RSTn         in   1   synchronous active-low reset
//   RET_VALID    in   1   an instruction commits this cycle
//   RET_INST     in   32  encoding of the committing instruction
//   RET_OUT      in   32  observation value of the committing instruction
//   NUM_INST     out  32  committed instruction count (wraps)
//   OUTPUT_PORT  out  32  RET_OUT of the most recent non-halting commit
//   HALT         out  1   terminate sequence has committed (sticky)
//   CYCLE_CNT    out  32  cycles since reset release, frozen at halt
//
// Build option
//   RETIRE_CYCLE_CNT_EN  when defined, adds the CYCLE_CNT port and counter.

module riscv_retire_monitor (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic        RET_VALID,
   input  logic [31:0] RET_INST,
   input  logic [31:0] RET_OUT,
   output logic [31:0] NUM_INST,
   output logic [31:0] OUTPUT_PORT,
   output logic        HALT
`ifdef RETIRE_CYCLE_CNT_EN
   ,
   output logic [31:0] CYCLE_CNT
`endif
);

   localparam logic [31:0] HALT_INST0 = 32'h00c00093;
   localparam logic [31:0] HALT_INST1 = 32'h00008067;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StArmed  = 2'd1,
      StHalted = 2'd2
   } state_e;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_num_inst;
   logic [31:0] w_num_inst_nxt;
   logic [31:0] r_output_port;
   logic [31:0] w_output_port_nxt;
   logic        w_is_inst0;
   logic        w_is_inst1;

   assign w_is_inst0 = (RET_INST == HALT_INST0);
   assign w_is_inst1 = (RET_INST == HALT_INST1);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_state       <= StRun;
         r_num_inst    <= 32'd0;
         r_output_port <= 32'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_num_inst    <= w_num_inst_nxt;
         r_output_port <= w_output_port_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_num_inst_nxt    = r_num_inst;
      w_output_port_nxt = r_output_port;
      // RET_INST is only looked at under RET_VALID, so bubbles carrying X are inert.
      if (RET_VALID) begin
         unique case (r_state)
            StRun: begin
               w_num_inst_nxt    = r_num_inst + 32'd1;
               w_output_port_nxt = RET_OUT;
               if (w_is_inst0) w_state_nxt = StArmed;
            end
            StArmed: begin
               w_num_inst_nxt = r_num_inst + 32'd1;
               if (w_is_inst1) begin
                  // The halting jalr is counted but its RET_OUT is not kept,
                  // so OUTPUT_PORT keeps the program result.
                  w_state_nxt = StHalted;
               end else begin
                  w_output_port_nxt = RET_OUT;
                  w_state_nxt       = w_is_inst0 ? StArmed : StRun;
               end
            end
            StHalted: ;
            default: w_state_nxt = StRun;
         endcase
      end
   end

   assign NUM_INST    = r_num_inst;
   assign OUTPUT_PORT = r_output_port;
   assign HALT        = (r_state == StHalted);

`ifdef RETIRE_CYCLE_CNT_EN
   logic [31:0] r_cycle_cnt;

   // Keyed off the current state, so the edge entering HALTED still counts.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_cycle_cnt <= 32'd0;
      end else if (r_state != StHalted) begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign CYCLE_CNT = r_cycle_cnt;
`endif

endmodule
